plusarg_watchdog: RTL and testbench
===================================

Name: plusarg_watchdog

Overview:
Cycle-limit watchdog that sits directly downstream of a plusarg-sourced limit value. Its `limit` input is driven by a plusarg reader's `out`, e.g. `+max_idle_cycles=N`.
- Counts prescaled ticks since the last forward-progress `kick`.
- On reaching the limit, raises a one-cycle `timeout` pulse and a sticky `expired` flag, for use by simulation monitors and fail logic.
- A limit of 0 disables the watchdog; this is the plusarg default.

Parameters:
WIDTH, 32, width of limit and count; matches the plusarg reader WIDTH.
PRESCALE, 1, clock cycles per count tick; legal range >= 1. Value 1 means a tick every cycle.

Ports:
clock  input  1  single clock; all state is on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
limit  input  WIDTH  tick limit from the plusarg reader; 0 = disabled.
enable  input  1  level; watchdog runs only while high.
kick  input  1  forward-progress pulse; restarts the count.
clear  input  1  acknowledges expiry and returns to IDLE.
count  output  WIDTH  current tick count, registered.
armed  output  1  high in the ARMED state.
expired  output  1  sticky; high in the EXPIRED state.
timeout  output  1  one-cycle pulse on the ARMED->EXPIRED transition.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE.
  - count=0, limit_q=0, prescaler=0.
  - armed=0, expired=0, timeout=0.
- All outputs are registered.
- IDLE:
  - count=0 and prescaler=0.
  - If enable=1 and limit!=0: capture limit_q<=limit and go to ARMED next edge with count=0.
  - Otherwise stay in IDLE.
  - kick and clear are ignored.
- ARMED:
  - Prescaler counts 0..PRESCALE-1 and asserts tick when it equals PRESCALE-1, then wraps to 0.
  - On tick, count<=count+1.
  - If count+1==limit_q on that tick: go to EXPIRED, set count<=limit_q, expired<=1, timeout<=1.
  - kick=1 or clear=1: count<=0 and prescaler<=0. This has priority over a coincident tick or expiry, so the watchdog does not expire that cycle.
  - enable=0: go to IDLE, clear count. This has priority over kick and tick.
- Limit sampling: limit is sampled only on IDLE->ARMED. Later changes to limit are ignored until the next re-arm.
- EXPIRED:
  - count holds limit_q; expired=1; timeout=0 after its single cycle.
  - kick and enable are ignored; expiry is sticky even if enable drops.
  - clear=1: go to IDLE next edge with count=0 and expired=0. Re-arm follows the normal IDLE rule.
- Width rules:
  - count never wraps, because expiry occurs at count==limit_q <= 2^WIDTH-1.
  - limit = all-ones is legal.
  - Prescaler width is clog2(PRESCALE), minimum 1.
- Latency, PRESCALE=1, enable held high from edge 0, limit=N:
  - armed=1, count=0 after edge 1.
  - count=k after edge 1+k.
  - expired=1, timeout=1, count=N after edge 1+N.
  - timeout=0 after edge 2+N.
- General expiry latency: 1 + N*PRESCALE cycles from arming, assuming no kicks.
- Reset asserted mid-operation (any state): outputs drop immediately to their reset values, without waiting for a clock edge.
- State encoding: 2 bits, IDLE=0, ARMED=1, EXPIRED=2. Encoding 3 is unreachable and recovers to IDLE.

Decomposition:
- Shared package `plusarg_watchdog_pkg`:
  - state encoding constants IDLE/ARMED/EXPIRED and the state width.
  - helper for the prescaler width, clog2 with minimum 1.
- One sub-module, `watchdog_prescaler`:
  - parameter PRESCALE.
  - inputs: clock, reset_n, run, restart.
  - output: tick.
  - When PRESCALE=1, tick = run, combinationally.
- The FSM, count and output registers live in `plusarg_watchdog`.

Test Plan:
- Disabled: limit=0, enable=1 for 100 cycles -> armed=0, count=0, timeout never asserts.
- Basic expiry: PRESCALE=1, limit=5, enable high from edge 0, no kick -> count steps 0..5 on edges 1..6; timeout=1 only after edge 6; expired stays 1 for 20 further cycles.
- Kick vs expiry collision: limit=4, kick on the cycle where count==3 -> count=0 next edge, no timeout. Expiry then occurs 4 edges later with count=4.
- Prescale: PRESCALE=3, limit=2 -> count=1 after edge 4, count=2 and timeout after edge 7.
- Clear and re-arm: after expiry at limit=3, change limit to 6, pulse clear -> IDLE with expired=0. Re-arm captures 6; expiry occurs 7 edges after clear. Changing limit to 2 while ARMED has no effect.
- Async reset mid-count: limit=10, assert reset_n low between edges at count=7 -> count=0 and armed=0 before the next edge. After release, re-arm with count restarting from 0.

Source files
------------

// File: rtl/plusarg_watchdog_pkg.sv
// Shared definitions for the plusarg-driven cycle-limit watchdog.
// State encoding and prescaler width helper.
package plusarg_watchdog_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    // clog2 with a floor of 1 so a divide-by-1 still has a legal vector
    function automatic int presc_width(input int presc);
        if (presc <= 2) begin
            return 1;
        end
        return $clog2(presc);
    endfunction

endpackage

// File: rtl/watchdog_prescaler.sv
// Tick generator: one tick every PRESCALE cycles while run is high.
// Dropping run or pulsing restart returns the phase to zero.
module watchdog_prescaler
    import plusarg_watchdog_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);

    // Divide-by-1 bypasses the counter entirely
    assign tick = (PRESCALE == 1) ? run : (run && at_last);

    // Next phase: wrap on the last phase, zero when idle or restarted
    always_comb begin
        cnt_d = cnt_q;
        if (!run || restart || at_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    // Phase register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/plusarg_watchdog.sv
// Cycle-limit watchdog fed by a plusarg limit; limit 0 disables it.
// Counts prescaled ticks since the last kick, then latches expiry.
module plusarg_watchdog
    import plusarg_watchdog_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] limit,
    input  logic             enable,
    input  logic             kick,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             armed,
    output logic             expired,
    output logic             timeout
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] limit_d;
    logic             armed_q;
    logic             armed_d;
    logic             expired_q;
    logic             expired_d;
    logic             timeout_q;
    logic             timeout_d;
    logic [WIDTH-1:0] count_inc;
    logic             tick;
    logic             run;
    logic             restart;

    assign run       = (state_q == ARMED) && enable;
    assign restart   = kick || clear;
    assign count_inc = count_q + WIDTH'(1);

    watchdog_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (run),
        .restart (restart),
        .tick    (tick)
    );

    // Next state, count and output flags; enable beats kick beats tick
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (enable && (limit != '0)) begin
                    limit_d = limit;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!enable) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (restart) begin
                    count_d = '0;
                end else if (tick) begin
                    if (count_inc == limit_q) begin
                        state_d   = EXPIRED;
                        count_d   = limit_q;
                        timeout_d = 1'b1;
                    end else begin
                        count_d = count_inc;
                    end
                end
            end
            EXPIRED: begin
                count_d = limit_q;
                if (clear) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
        armed_d   = (state_d == ARMED);
        expired_d = (state_d == EXPIRED);
    end

    // State, count, captured limit and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            limit_q   <= '0;
            armed_q   <= 1'b0;
            expired_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            armed_q   <= armed_d;
            expired_q <= expired_d;
            timeout_q <= timeout_d;
        end
    end

    assign count   = count_q;
    assign armed   = armed_q;
    assign expired = expired_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_plusarg_watchdog.sv
// Self-checking bench for plusarg_watchdog.
// Vector table plus directed multi-cycle sequences.
module tb_plusarg_watchdog;

    logic        clock;
    logic        reset_n;
    logic [31:0] limit;
    logic        enable;
    logic        kick;
    logic        clear;

    logic [31:0] count1;
    logic        armed1;
    logic        expired1;
    logic        timeout1;
    logic [31:0] count3;
    logic        armed3;
    logic        expired3;
    logic        timeout3;

    int checks;
    int errors;

    typedef struct {
        logic        en;
        logic [31:0] lim;
        logic        kck;
        logic        clr;
        logic [31:0] cnt;
        logic        arm;
        logic        exp;
        logic        to;
    } vec_t;

    vec_t vecs[26];

    plusarg_watchdog #(.WIDTH(32), .PRESCALE(1)) u1 (
        .clock   (clock),
        .reset_n (reset_n),
        .limit   (limit),
        .enable  (enable),
        .kick    (kick),
        .clear   (clear),
        .count   (count1),
        .armed   (armed1),
        .expired (expired1),
        .timeout (timeout1)
    );

    plusarg_watchdog #(.WIDTH(32), .PRESCALE(3)) u3 (
        .clock   (clock),
        .reset_n (reset_n),
        .limit   (limit),
        .enable  (enable),
        .kick    (kick),
        .clear   (clear),
        .count   (count3),
        .armed   (armed3),
        .expired (expired3),
        .timeout (timeout3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input logic en, input logic [31:0] lim,
                                input logic kck, input logic clr,
                                input logic [31:0] cnt, input logic arm,
                                input logic exp, input logic to);
        vec_t v;
        v.en = en; v.lim = lim; v.kck = kck; v.clr = clr;
        v.cnt = cnt; v.arm = arm; v.exp = exp; v.to = to;
        return v;
    endfunction

    initial begin
        int ps_cnt[8];
        checks = 0;
        errors = 0;

        // basic expiry, limit 5
        vecs[0]  = mk(1, 5, 0, 0, 0, 1, 0, 0);
        vecs[1]  = mk(1, 5, 0, 0, 1, 1, 0, 0);
        vecs[2]  = mk(1, 5, 0, 0, 2, 1, 0, 0);
        vecs[3]  = mk(1, 5, 0, 0, 3, 1, 0, 0);
        vecs[4]  = mk(1, 5, 0, 0, 4, 1, 0, 0);
        vecs[5]  = mk(1, 5, 0, 0, 5, 0, 1, 1);
        vecs[6]  = mk(1, 5, 0, 0, 5, 0, 1, 0);
        vecs[7]  = mk(0, 5, 0, 0, 5, 0, 1, 0);
        vecs[8]  = mk(1, 5, 1, 0, 5, 0, 1, 0);
        vecs[9]  = mk(0, 5, 0, 1, 0, 0, 0, 0);
        vecs[10] = mk(0, 5, 0, 0, 0, 0, 0, 0);
        // kick colliding with expiry, limit 4
        vecs[11] = mk(1, 4, 0, 0, 0, 1, 0, 0);
        vecs[12] = mk(1, 4, 0, 0, 1, 1, 0, 0);
        vecs[13] = mk(1, 4, 0, 0, 2, 1, 0, 0);
        vecs[14] = mk(1, 4, 0, 0, 3, 1, 0, 0);
        vecs[15] = mk(1, 4, 1, 0, 0, 1, 0, 0);
        vecs[16] = mk(1, 4, 0, 0, 1, 1, 0, 0);
        vecs[17] = mk(1, 4, 0, 0, 2, 1, 0, 0);
        vecs[18] = mk(1, 4, 0, 0, 3, 1, 0, 0);
        vecs[19] = mk(1, 4, 0, 0, 4, 0, 1, 1);
        vecs[20] = mk(0, 4, 0, 1, 0, 0, 0, 0);
        // clear while armed restarts; enable drop wins over kick
        vecs[21] = mk(1, 4, 0, 0, 0, 1, 0, 0);
        vecs[22] = mk(1, 4, 0, 0, 1, 1, 0, 0);
        vecs[23] = mk(1, 4, 0, 1, 0, 1, 0, 0);
        vecs[24] = mk(1, 4, 0, 0, 1, 1, 0, 0);
        vecs[25] = mk(0, 4, 1, 0, 0, 0, 0, 0);

        ps_cnt = '{0, 0, 0, 1, 1, 1, 2, 2};

        reset_n = 1'b0;
        limit   = '0;
        enable  = 1'b0;
        kick    = 1'b0;
        clear   = 1'b0;
        #1;
        chk("rst.count",   count1,   0);
        chk("rst.armed",   armed1,   0);
        chk("rst.expired", expired1, 0);
        chk("rst.timeout", timeout1, 0);
        chk("rst.count3",  count3,   0);
        chk("rst.armed3",  armed3,   0);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;

        // limit 0 keeps the watchdog disabled
        limit  = 0;
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("dis.armed",   armed1,   0);
            chk("dis.count",   count1,   0);
            chk("dis.timeout", timeout1, 0);
        end
        enable = 1'b0;
        step();

        for (int i = 0; i < 26; i++) begin
            enable = vecs[i].en;
            limit  = vecs[i].lim;
            kick   = vecs[i].kck;
            clear  = vecs[i].clr;
            step();
            chk($sformatf("vec%0d.count", i),   count1,   vecs[i].cnt);
            chk($sformatf("vec%0d.armed", i),   armed1,   vecs[i].arm);
            chk($sformatf("vec%0d.expired", i), expired1, vecs[i].exp);
            chk($sformatf("vec%0d.timeout", i), timeout1, vecs[i].to);
        end
        kick = 1'b0;
        step();

        // expire at 3, hold, clear, re-arm at 6 ignoring later change
        enable = 1'b1;
        limit  = 3;
        repeat (4) step();
        chk("ra.exp_count",   count1,   3);
        chk("ra.exp_timeout", timeout1, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("ra.hold_expired", expired1, 1);
            chk("ra.hold_timeout", timeout1, 0);
        end
        limit = 6;
        clear = 1'b1;
        step();
        chk("ra.clr_expired", expired1, 0);
        chk("ra.clr_armed",   armed1,   0);
        chk("ra.clr_count",   count1,   0);
        clear = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k == 2) limit = 2;
            step();
            chk("ra.count",   count1,   k - 1);
            chk("ra.timeout", timeout1, (k == 7) ? 1 : 0);
            chk("ra.armed",   armed1,   (k < 7) ? 1 : 0);
        end
        enable = 1'b0;
        clear  = 1'b1;
        step();
        clear  = 1'b0;

        // prescale 3, limit 2 on the second instance
        #1 reset_n = 1'b0;
        #1;
        chk("ps.rst_count", count3, 0);
        reset_n = 1'b1;
        enable  = 1'b1;
        limit   = 2;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("ps.e%0d.count", e), count3, ps_cnt[e-1]);
            chk($sformatf("ps.e%0d.timeout", e), timeout3,
                (e == 7) ? 1 : 0);
            chk($sformatf("ps.e%0d.expired", e), expired3,
                (e >= 7) ? 1 : 0);
        end
        enable = 1'b0;
        clear  = 1'b1;
        step();
        clear  = 1'b0;

        // asynchronous reset in the middle of a count
        enable = 1'b1;
        limit  = 10;
        repeat (8) step();
        chk("ar.count7", count1, 7);
        chk("ar.armed",  armed1, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar.async_count",   count1,   0);
        chk("ar.async_armed",   armed1,   0);
        chk("ar.async_expired", expired1, 0);
        chk("ar.async_timeout", timeout1, 0);
        #1 reset_n = 1'b1;
        step();
        chk("ar.rearm_armed", armed1, 1);
        chk("ar.rearm_count", count1, 0);
        step();
        chk("ar.next_count",  count1, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
